// File: rtl/fmul_iter_if.sv
// Operand / result bundle for the iterative binary32 multiplier fmul_iter.
interface fmul_iter_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  rm;
  logic        fmul;
  logic        ena;
  logic [31:0] s;
  logic        ready;
  logic        busy;
  logic        stall;
  logic [3:0]  count;

  modport master (output a, b, rm, fmul, ena, input s, ready, busy, stall, count);
  modport slave  (input a, b, rm, fmul, ena, output s, ready, busy, stall, count);
endinterface

// File: rtl/fmul_iter.sv
// Iterative binary32 multiplier: radix-4 shift-add over 12 cycles, then one normalize/round cycle.
// Define FMUL_DENORM_EN to build denormal operand support and gradual-underflow results.
module fmul_iter (
  input  logic       clk,
  input  logic       clr,
  fmul_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, RND = 2'd2} state_t;

  state_t             state_r;
  logic               sign_r;
  logic [1:0]         rm_r;
  logic               nan_r;
  logic               inf_r;
  logic               zero_r;
  logic [23:0]        a_sh_r;
  logic [23:0]        b_sig_r;
  logic [25:0]        b3_r;
  logic signed [9:0]  exp_r;
  logic [3:0]         count_r;
  logic [47:0]        p_r;
  logic [31:0]        s_r;
  logic               ready_r;

  logic [7:0]         ea_s;
  logic [7:0]         eb_s;
  logic [22:0]        fa_s;
  logic [22:0]        fb_s;
  logic               a_nan_s;
  logic               b_nan_s;
  logic               a_inf_s;
  logic               b_inf_s;
  logic               a_zero_s;
  logic               b_zero_s;
  logic [23:0]        a_sig_s;
  logic [23:0]        b_sig_s;
  logic [25:0]        b3_s;
  logic signed [9:0]  a_exp_s;
  logic signed [9:0]  b_exp_s;
  logic signed [9:0]  exp_s;

  logic [25:0]        mult_s;
  logic [25:0]        acc_s;
  logic [47:0]        p_next_s;

  logic [47:0]        n_s;
  logic [47:0]        d_s;
  logic signed [9:0]  e1_s;
  logic signed [9:0]  exp_pre_s;
  logic signed [9:0]  exp_f_s;
  logic               lost_s;
  logic [23:0]        mant_s;
  logic               guard_s;
  logic               sticky_s;
  logic               inc_s;
  logic [24:0]        mrnd_s;
  logic               tiny_s;
  logic               uflow_s;
  logic [7:0]         efield_s;
  logic [31:0]        ovf_s;
  logic [31:0]        res_s;
`ifdef FMUL_DENORM_EN
  logic [5:0]         lz_s;
  logic [9:0]         sh_s;

  function automatic logic [5:0] lzc48(input logic [47:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd48;
    found = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(47 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction
`endif

  // Operand field decode used in the accept cycle
  always_comb begin
    ea_s    = bus.a[30:23];
    eb_s    = bus.b[30:23];
    fa_s    = bus.a[22:0];
    fb_s    = bus.b[22:0];
    a_nan_s = (ea_s == 8'hFF) && (fa_s != 23'd0);
    b_nan_s = (eb_s == 8'hFF) && (fb_s != 23'd0);
    a_inf_s = (ea_s == 8'hFF) && (fa_s == 23'd0);
    b_inf_s = (eb_s == 8'hFF) && (fb_s == 23'd0);
`ifdef FMUL_DENORM_EN
    a_zero_s = (ea_s == 8'h00) && (fa_s == 23'd0);
    b_zero_s = (eb_s == 8'h00) && (fb_s == 23'd0);
`else
    a_zero_s = (ea_s == 8'h00);
    b_zero_s = (eb_s == 8'h00);
`endif
    a_sig_s = (ea_s == 8'h00) ? {1'b0, fa_s} : {1'b1, fa_s};
    b_sig_s = (eb_s == 8'h00) ? {1'b0, fb_s} : {1'b1, fb_s};
    a_exp_s = (ea_s == 8'h00) ? 10'sd1 : $signed({2'b00, ea_s});
    b_exp_s = (eb_s == 8'h00) ? 10'sd1 : $signed({2'b00, eb_s});
    exp_s   = a_exp_s + b_exp_s - 10'sd127;
    b3_s    = {2'b00, b_sig_s} + {1'b0, b_sig_s, 1'b0};
  end

  // One radix-4 step: add the selected multiple of b above P, then shift right by two
  always_comb begin
    case (a_sh_r[1:0])
      2'b00:   mult_s = 26'd0;
      2'b01:   mult_s = {2'b00, b_sig_r};
      2'b10:   mult_s = {1'b0, b_sig_r, 1'b0};
      2'b11:   mult_s = b3_r;
      default: mult_s = 26'd0;
    endcase
    acc_s    = {2'b00, p_r[47:24]} + mult_s;
    p_next_s = {acc_s, p_r[23:2]};
  end

  // Normalize, optional denormal right-shift, round, and special-case override
  always_comb begin
    lost_s = 1'b0;
`ifdef FMUL_DENORM_EN
    lz_s = lzc48(p_r);
    n_s  = p_r << lz_s;
    e1_s = exp_r + 10'sd1 - $signed({4'b0000, lz_s});
    if (e1_s <= 10'sd0) begin
      sh_s      = 10'(10'sd1 - e1_s);
      d_s       = n_s >> sh_s;
      lost_s    = ((d_s << sh_s) != n_s);
      exp_pre_s = 10'sd1;
    end else begin
      sh_s      = 10'd0;
      d_s       = n_s;
      exp_pre_s = e1_s;
    end
`else
    if (p_r[47]) begin
      n_s  = p_r;
      e1_s = exp_r + 10'sd1;
    end else begin
      n_s  = {p_r[46:0], 1'b0};
      e1_s = exp_r;
    end
    d_s       = n_s;
    exp_pre_s = e1_s;
`endif
    mant_s   = d_s[47:24];
    guard_s  = d_s[23];
    sticky_s = (|d_s[22:0]) | lost_s;
    case (rm_r)
      2'b00:   inc_s = guard_s & (sticky_s | mant_s[0]);
      2'b01:   inc_s = sign_r & (guard_s | sticky_s);
      2'b10:   inc_s = ~sign_r & (guard_s | sticky_s);
      2'b11:   inc_s = 1'b0;
      default: inc_s = 1'b0;
    endcase
    mrnd_s  = {1'b0, mant_s} + {24'd0, inc_s};
    // A carry out of the significand leaves the fraction at zero, so only the exponent moves
    exp_f_s = exp_pre_s + $signed({9'd0, mrnd_s[24]});
    tiny_s  = ~(mrnd_s[24] | mrnd_s[23]);
`ifdef FMUL_DENORM_EN
    uflow_s  = 1'b0;
    efield_s = tiny_s ? 8'h00 : exp_f_s[7:0];
`else
    uflow_s  = (exp_f_s <= 10'sd0) | tiny_s;
    efield_s = exp_f_s[7:0];
`endif
    case (rm_r)
      2'b00:   ovf_s = {sign_r, 31'h7F800000};
      2'b01:   ovf_s = sign_r ? {sign_r, 31'h7F800000} : {sign_r, 31'h7F7FFFFF};
      2'b10:   ovf_s = sign_r ? {sign_r, 31'h7F7FFFFF} : {sign_r, 31'h7F800000};
      2'b11:   ovf_s = {sign_r, 31'h7F7FFFFF};
      default: ovf_s = {sign_r, 31'h7F800000};
    endcase
    if (nan_r) begin
      res_s = 32'h7FC00000;
    end else if (inf_r && zero_r) begin
      res_s = 32'h7FC00000;
    end else if (inf_r) begin
      res_s = {sign_r, 8'hFF, 23'd0};
    end else if (zero_r) begin
      res_s = {sign_r, 31'd0};
    end else if (exp_f_s >= 10'sd255) begin
      res_s = ovf_s;
    end else if (uflow_s) begin
      res_s = {sign_r, 31'd0};
    end else begin
      res_s = {sign_r, efield_s, mrnd_s[22:0]};
    end
  end

  // Control FSM, operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= IDLE;
      sign_r  <= 1'b0;
      rm_r    <= 2'b00;
      nan_r   <= 1'b0;
      inf_r   <= 1'b0;
      zero_r  <= 1'b0;
      a_sh_r  <= 24'd0;
      b_sig_r <= 24'd0;
      b3_r    <= 26'd0;
      exp_r   <= 10'sd0;
      count_r <= 4'd0;
      p_r     <= 48'd0;
      s_r     <= 32'd0;
      ready_r <= 1'b0;
    end else if (bus.ena) begin
      ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.fmul) begin
            sign_r  <= bus.a[31] ^ bus.b[31];
            rm_r    <= bus.rm;
            nan_r   <= a_nan_s | b_nan_s;
            inf_r   <= a_inf_s | b_inf_s;
            zero_r  <= a_zero_s | b_zero_s;
            a_sh_r  <= a_sig_s;
            b_sig_r <= b_sig_s;
            b3_r    <= b3_s;
            exp_r   <= exp_s;
            count_r <= 4'd11;
            p_r     <= 48'd0;
            state_r <= MUL;
          end else begin
            state_r <= IDLE;
          end
        end
        MUL: begin
          p_r    <= p_next_s;
          a_sh_r <= {2'b00, a_sh_r[23:2]};
          if (count_r == 4'd0) begin
            state_r <= RND;
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        RND: begin
          s_r     <= res_s;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.s     = s_r;
  assign bus.ready = ready_r;
  assign bus.count = count_r;
  assign bus.busy  = (state_r == MUL) || (state_r == RND);
  assign bus.stall = ((state_r == IDLE) && bus.fmul && bus.ena) || (state_r == MUL) || (state_r == RND);

endmodule

// File: tb/tb_fmul_iter.sv
// Self-checking bench for fmul_iter: directed table, timing/reset/freeze sequences, random vs. model.
module tb_fmul_iter;

  logic clk;
  logic clr;
  fmul_iter_if bif ();

  fmul_iter dut (.clk(clk), .clr(clr), .bus(bif));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Exact rounding of the significand product to binary32, written from the IEEE rules.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    logic        sg, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, gt, eq, nz, inc;
    int          ea, eb, x, k, qx, sh, be;
    logic [63:0] fa, fb, m, r, rem, half;
    sg = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = 64'(a[22:0]);
    fb = 64'(b[22:0]);
    a_nan = (ea == 255) && (fa != 64'd0);
    b_nan = (eb == 255) && (fb != 64'd0);
    a_inf = (ea == 255) && (fa == 64'd0);
    b_inf = (eb == 255) && (fb == 64'd0);
`ifdef FMUL_DENORM_EN
    a_zero = (ea == 0) && (fa == 64'd0);
    b_zero = (eb == 0) && (fb == 64'd0);
`else
    a_zero = (ea == 0);
    b_zero = (eb == 0);
`endif
    if (a_nan || b_nan) return 32'h7FC00000;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
    if (a_inf || b_inf) return {sg, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {sg, 31'h0};
    if (ea != 0) fa = fa + 64'h800000;
    if (eb != 0) fb = fb + 64'h800000;
    m = fa * fb;
    x = ((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 300;
    k = 47;
    while (k > 0 && m[k] == 1'b0) k--;
`ifdef FMUL_DENORM_EN
    qx = (k + x - 23 > -149) ? (k + x - 23) : -149;
`else
    qx = k + x - 23;
`endif
    sh = qx - x;
    gt = 1'b0; eq = 1'b0; nz = 1'b0;
    if (sh <= 0) begin
      r = m << (-sh);
    end else if (sh >= 60) begin
      r  = 64'd0;
      nz = 1'b1;
    end else begin
      r    = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      gt   = rem > half;
      eq   = rem == half;
      nz   = rem != 64'd0;
    end
    case (rm)
      2'd0:    inc = gt || (eq && r[0]);
      2'd1:    inc = sg && nz;
      2'd2:    inc = !sg && nz;
      default: inc = 1'b0;
    endcase
    r = r + 64'(inc);
    if (r == (64'd1 << 24)) begin
      r  = 64'd1 << 23;
      qx = qx + 1;
    end
    if (r == 64'd0) return {sg, 31'h0};
    be = (r >= (64'd1 << 23)) ? qx + 150 : 0;
`ifndef FMUL_DENORM_EN
    if (be <= 0) return {sg, 31'h0};
`endif
    if (be >= 255) begin
      case (rm)
        2'd0:    return {sg, 31'h7F800000};
        2'd1:    return sg ? {sg, 31'h7F800000} : {sg, 31'h7F7FFFFF};
        2'd2:    return sg ? {sg, 31'h7F7FFFFF} : {sg, 31'h7F800000};
        default: return {sg, 31'h7F7FFFFF};
      endcase
    end
    return {sg, 8'(be), r[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int          cls;
    logic [7:0]  e;
    logic [22:0] f;
    cls = int'($urandom_range(0, 9));
    f   = 23'($urandom);
    if ($urandom_range(0, 7) == 0) f = 23'd0;
    case (cls)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(1, 40));
      4, 5:    e = 8'($urandom_range(200, 254));
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Expected {s, stall, busy, ready, count} j cycles after an accept (j=0 is the accept cycle)
  function automatic logic [63:0] ctl(input int j, input logic [31:0] sv);
    logic [3:0] c;
    logic       act;
    c   = (j >= 1 && j <= 12) ? 4'(12 - j) : 4'd0;
    act = (j >= 1 && j <= 13);
    return 64'({sv, act, act, (j == 14), c});
  endfunction

  function automatic logic [63:0] obs();
    return 64'({bif.s, bif.stall, bif.busy, bif.ready, bif.count});
  endfunction

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                    output logic [31:0] res, output int lat);
    @(negedge clk);
    bif.a = a; bif.b = b; bif.rm = rm; bif.fmul = 1'b1;
    lat = -1;
    res = 32'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bif.fmul = 1'b0;
      if (bif.ready) begin
        res = bif.s;
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] res, a, b;
    logic [1:0]  rm;
    int          lat, j, kk;
    logic [31:0] sv;

    bif.a = 32'h0; bif.b = 32'h0; bif.rm = 2'd0; bif.fmul = 1'b0; bif.ena = 1'b1;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    check64("reset_state", obs(), 64'd0);

    // Basic timing, then a back-to-back accept in the ready cycle
    @(negedge clk);
    bif.a = 32'h3FC00000; bif.b = 32'h40000000; bif.rm = 2'd0; bif.fmul = 1'b1;
    #1;
    check64("stall_accept", 64'(bif.stall), 64'd1);
    check64("busy_accept", 64'(bif.busy), 64'd0);
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (k == 1 || k == 15) bif.fmul = 1'b0;
      j  = (k <= 14) ? k : k - 14;
      sv = (k < 14) ? 32'h0 : ((k < 28) ? 32'h40400000 : 32'h40C00000);
      check64($sformatf("timing_k%0d", k), obs(), ctl(j, sv));
      if (k == 14) begin
        bif.a = 32'h40000000; bif.b = 32'h40400000; bif.fmul = 1'b1;
        #1;
        check64("stall_b2b", 64'(bif.stall), 64'd1);
      end
    end

    // Mid-operation clear, then a fresh accept two cycles later
    @(negedge clk);
    bif.a = 32'h3FC00000; bif.b = 32'h40000000; bif.rm = 2'd0; bif.fmul = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bif.fmul = 1'b0;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check64("clr_mid_op", obs(), 64'd0);
    op(32'h40400000, 32'h40400000, 2'd0, res, lat);
    check64("clr_fresh_val", 64'(res), 64'h41100000);
    check64("clr_fresh_lat", 64'(lat), 64'd14);

    // Clear and request together: clear wins
    @(negedge clk);
    clr = 1'b1; bif.fmul = 1'b1;
    @(negedge clk);
    clr = 1'b0; bif.fmul = 1'b0;
    #1;
    check64("clr_beats_fmul", 64'({bif.busy, bif.stall}), 64'd0);

    // Request with ena low in IDLE is not accepted
    @(negedge clk);
    bif.ena = 1'b0; bif.fmul = 1'b1;
    #1;
    check64("ena0_stall", 64'(bif.stall), 64'd0);
    @(negedge clk);
    bif.fmul = 1'b0; bif.ena = 1'b1;
    #1;
    check64("ena0_no_accept", 64'(bif.busy), 64'd0);

    // Three frozen cycles during MUL plus an ignored request with new operands
    @(negedge clk);
    bif.a = 32'h3FC00000; bif.b = 32'h40400000; bif.rm = 2'd0; bif.fmul = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) bif.fmul = 1'b0;
      kk = (k <= 4) ? k : ((k <= 7) ? 4 : k - 3);
      check64($sformatf("freeze_k%0d", k), obs() & 64'h7F, ctl(kk, 32'h0) & 64'h7F);
      if (kk == 14) check64("freeze_val", 64'(bif.s), 64'h40900000);
      if (k == 4) bif.ena = 1'b0;
      if (k == 7) bif.ena = 1'b1;
      if (k == 9) begin
        bif.a = 32'h41000000; bif.b = 32'h41000000; bif.rm = 2'd3; bif.fmul = 1'b1;
      end
      if (k == 11) bif.fmul = 1'b0;
    end

    // Directed table
    vecs.push_back('{32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 2'd0, 32'h3F800000});
    vecs.push_back('{32'hBFC00000, 32'h40000000, 2'd0, 32'hC0400000});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 2'd3, 32'h3F800002});
    vecs.push_back('{32'hBF800001, 32'h3F800001, 2'd1, 32'hBF800003});
    vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000});
    vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 2'd3, 32'h7F7FFFFF});
    vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF});
    vecs.push_back('{32'hFF7FFFFF, 32'h40000000, 2'd1, 32'hFF800000});
    vecs.push_back('{32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF7FFFFF});
    vecs.push_back('{32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000});
    vecs.push_back('{32'hFFC00000, 32'h3F800000, 2'd0, 32'h7FC00000});
    vecs.push_back('{32'h80000000, 32'h40000000, 2'd0, 32'h80000000});
    vecs.push_back('{32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000});
`ifdef FMUL_DENORM_EN
    vecs.push_back('{32'h00800000, 32'h3F000000, 2'd0, 32'h00400000});
    vecs.push_back('{32'h00000001, 32'h3F000000, 2'd0, 32'h00000000});
    vecs.push_back('{32'h00000001, 32'h3F000000, 2'd2, 32'h00000001});
`else
    vecs.push_back('{32'h00800000, 32'h3F000000, 2'd0, 32'h00000000});
    vecs.push_back('{32'h00400000, 32'h40000000, 2'd0, 32'h00000000});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].rm, res, lat);
      check64($sformatf("vec%0d_%08h_x_%08h_rm%0d", i, vecs[i].a, vecs[i].b, vecs[i].rm),
              64'(res), 64'(vecs[i].exp));
      check64($sformatf("vec%0d_lat", i), 64'(lat), 64'd14);
    end

    // Randomized operands against the reference model
    for (int i = 0; i < 300; i++) begin
      a  = rand_op();
      b  = rand_op();
      rm = 2'($urandom_range(0, 3));
      op(a, b, rm, res, lat);
      check64($sformatf("rand%0d_%08h_x_%08h_rm%0d", i, a, b, rm), 64'(res), 64'(ref_mul(a, b, rm)));
      check64($sformatf("rand%0d_lat", i), 64'(lat), 64'd14);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fmul_iter.md
# fmul_iter

Iterative single-precision multiplier for the FPU execute stage, the multiplicative counterpart of the Newton divider. It accepts an IEEE-754 binary32 pair in the ID stage, forms the 24×24 significand product with a radix-4 shift-add datapath over 12 cycles, then normalizes and rounds in a single cycle. While it works it drives the same `busy`/`stall` pipeline handshake as the divider.

## Interface
Parameters: none.

- `clk`  in  1  clock; all state updates on the rising edge
- `clr`  in  1  reset, synchronous, active-high
- `a`, `b`  in  32  binary32 operands, s = a × b; sampled only in the accept cycle
- `rm`  in  2  rounding mode: 00 nearest-even, 01 toward −∞, 10 toward +∞, 11 toward zero
- `fmul`  in  1  ID-stage request (i_fmul)
- `ena`  in  1  enable; 0 freezes every register
- `s`  out  32  result, registered, held until the next result
- `ready`  out  1  one-cycle pulse when `s` updates
- `busy`  out  1  operation in progress
- `stall`  out  1  pipeline stall request
- `count`  out  4  remaining MUL iterations

## Operation
- FSM has three states: IDLE, MUL and RND.
- **Accept:** in IDLE with `fmul & ena`, the block does the following.
  - Latches sign = a[31]^b[31], `rm`, and special flags (exponent 00/ff, fraction 00 for each operand).
  - Latches significands: normal operands use {1,frac}; denormal operands use {0,frac} with exponent 1.
  - Precomputes 3×b_sig (26 bits).
  - Computes biased exponent = ea + eb − 127, held in 10 bits signed.
  - Sets count=11, clears the 48-bit product register P, and goes to MUL.
- **MUL (12 cycles):** each cycle adds {0, b, 2b, 3b} × (the two LSBs of the a-shift register) into the upper part of P, then shifts P and a right by 2. When count==0 the FSM goes to RND; otherwise count decrements.
- **RND:**
  - Normalize: if P[47]=1, exponent+1. Otherwise left-shift by the leading-zero count (denormal inputs) and subtract that count from the exponent.
  - If the exponent is ≤0, right-shift into denormal form with sticky; the exponent field becomes 0.
  - Form guard and sticky, then round per `rm`. A round carry-out increments the exponent.
  - Registers `s` and pulses `ready`, then returns to IDLE.
- **Overflow** (exponent ≥ 255 after rounding) depends on `rm` and sign:
  - rm=00: INF.
  - rm=01: MAX if +, INF if −.
  - rm=10: INF if +, MAX if −.
  - rm=11: MAX.
  - MAX = 0x7F7FFFFF, INF = 0x7F800000, each with the sign applied.
- **Specials** override the computed result:
  - NaN × any = 0x7FC00000.
  - INF × 0 = 0x7FC00000.
  - INF × (nonzero) = ±INF.
  - 0 × (finite) = ±0.
  - The NaN result is always the positive quiet NaN; zero and INF results carry the sign.
- `fmul` arriving while `busy` is ignored.
- `clr` in any state: on the next edge the FSM returns to IDLE, and `s`=0, `count`=0, `ready`=0, P=0.

## Timing
- Reset values: `s`=0x00000000, `ready`=0, `busy`=0, `stall`=0, `count`=0.
- Combinational outputs:
  - `stall` = (IDLE & `fmul` & `ena`) | MUL | RND.
  - `busy` = MUL | RND.
- With the accept in cycle T:
  - MUL occupies T+1..T+12, with `count` 11→0.
  - RND occupies T+13.
  - `s` is valid and `ready`=1 in T+14.
  - `stall` is high exactly in T..T+13, which is 14 cycles.
- Back-to-back: a new `fmul` in T+14 is accepted; `s` keeps the old value until that operation's own T+14.
- `ena`=0 holds the state, `count`, P and `s`. Latency extends by one cycle per frozen cycle, and `stall` and `busy` keep their values.
- When `clr` and `fmul` are both asserted, `clr` wins and no accept occurs.

## Configuration
- `FMUL_DENORM_EN` defined: denormal operands are used at full value, and tiny results are produced as denormals with correct rounding.
- `FMUL_DENORM_EN` undefined:
  - Operands with exponent 00 are treated as ±0.
  - Any result whose rounded exponent is ≤0 becomes a signed zero.
  - The leading-zero shifter and the denormal right-shifter are not built.

## Test plan
- **Basic product, rm=00:** 0x3FC00000 × 0x40000000 → s=0x40400000.
  - `ready` pulses at T+14.
  - `stall` is high for T..T+13.
  - `count` steps 11..0 over T+1..T+12.
- **Overflow:**
  - 0x7F7FFFFF × 0x40000000 with rm=00 → 0x7F800000.
  - The same operands with rm=11 → 0x7F7FFFFF.
  - 0xFF7FFFFF × 0x40000000 with rm=01 → 0xFF800000.
- **Specials:**
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0xFFC00000 × 0x3F800000 → 0x7FC00000.
  - 0x80000000 × 0x40000000 → 0x80000000.
- **Denormals:**
  - With `FMUL_DENORM_EN`, 0x00800000 × 0x3F000000 → 0x00400000.
  - With `FMUL_DENORM_EN`, 0x00000001 × 0x3F000000 → 0x00000000 at rm=00 (tie to even) and 0x00000001 at rm=10.
  - Without the macro, 0x00800000 × 0x3F000000 → 0x00000000.
- **Mid-operation reset:** `clr` pulsed at T+6 → in T+7, `busy`=0, `stall`=0, `s`=0, `count`=0. A fresh accept at T+8 yields the correct result at T+22.
- **Freeze and ignored request:**
  - `ena`=0 for 3 cycles during MUL → `ready` moves to T+17 with an unchanged value.
  - `fmul` pulsed with new operands during MUL does not alter the result.
